// File: rtl/nand_sched_pkg.sv
// Shared encodings for the NAND command scheduler: request ops, flash opcodes,
// status codes and FSM states.
`timescale 1ns/1ps
package nand_sched_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_ERASE   = 2'b11
  } req_op_e;

  localparam logic [7:0] FLASH_OPC_WRITE = 8'h01;
  localparam logic [7:0] FLASH_OPC_READ  = 8'h02;
  localparam logic [7:0] FLASH_OPC_ERASE = 8'h03;

  typedef enum logic [1:0] {
    STS_OK      = 2'b00,
    STS_NORESP  = 2'b01,
    STS_TIMEOUT = 2'b10,
    STS_BADOP   = 2'b11
  } sts_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_WAIT   = 2'b10,
    ST_REPORT = 2'b11
  } sched_state_e;

  function automatic logic [7:0] flash_opcode(input req_op_e op);
    logic [7:0] opc;
    case (op)
      OP_WRITE: opc = FLASH_OPC_WRITE;
      OP_READ:  opc = FLASH_OPC_READ;
      OP_ERASE: opc = FLASH_OPC_ERASE;
      default:  opc = 8'h00;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/nand_req_fifo.sv
// Synchronous show-ahead FIFO holding pending {op, row} requests.
// A push while full is dropped, even if a pop happens in the same cycle.
`timescale 1ns/1ps
module nand_req_fifo #(
  parameter  int WIDTH = 26,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is defined
  // solely by the pointers and count, which are.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/nand_cmd_scheduler.sv
// Queues write/read/erase requests and issues them one at a time to the NAND
// flash controller, reporting one status record per request.
`timescale 1ns/1ps
module nand_cmd_scheduler
  import nand_sched_pkg::*;
#(
  parameter  int QDEPTH      = 4,
  parameter  int TIMEOUT_CYC = 2400000,
  parameter  int ROW_W       = 24,
  localparam int QCW         = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  input  logic [ROW_W-1:0] req_row,
  output logic             req_ready,
  output logic [31:0]      cmd,
  output logic             start_trs,
  input  logic             done_w,
  input  logic             done_r,
  input  logic             done_e,
  input  logic             busy_noresp,
  output logic             sts_valid,
  output logic [1:0]       sts_code,
  output logic [1:0]       sts_op,
  output logic [ROW_W-1:0] sts_row,
  output logic [QCW-1:0]   q_count,
  output logic             idle
);

  localparam int            TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  sched_state_e     r_state, w_state_nxt;
  sts_code_e        r_code, w_code_nxt;
  req_op_e          r_cur_op;
  logic [ROW_W-1:0] r_cur_row;
  logic [31:0]      r_cmd;
  logic [TW-1:0]    r_timer;

  logic             w_load, w_pop, w_full, w_empty, w_done_match;
  logic [ROW_W+1:0] w_head;
  req_op_e          w_head_op;
  logic [ROW_W-1:0] w_head_row;

  nand_req_fifo #(
    .WIDTH (ROW_W + 2),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (w_pop),
    .din   ({req_op, req_row}),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (q_count)
  );

  assign w_head_op  = req_op_e'(w_head[ROW_W+1:ROW_W]);
  assign w_head_row = w_head[ROW_W-1:0];

  // Only the done pulse belonging to the operation in flight completes it.
  always_comb begin
    w_done_match = 1'b0;
    case (r_cur_op)
      OP_WRITE: w_done_match = done_w;
      OP_READ:  w_done_match = done_r;
      OP_ERASE: w_done_match = done_e;
      default:  w_done_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_cur_op == OP_ILLEGAL) begin
          w_code_nxt  = STS_BADOP;
          w_state_nxt = ST_REPORT;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (busy_noresp) begin
          w_code_nxt  = STS_NORESP;
          w_state_nxt = ST_REPORT;
        end else if (w_done_match) begin
          w_code_nxt  = STS_OK;
          w_state_nxt = ST_REPORT;
        end else if (r_timer == TIMER_LAST) begin
          w_code_nxt  = STS_TIMEOUT;
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        w_pop       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The request head stays in the FIFO until REPORT, so it is counted as
  // occupancy for the whole time it is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_op  <= OP_ILLEGAL;
      r_cur_row <= '0;
      r_cmd     <= '0;
      r_code    <= STS_OK;
      r_timer   <= '0;
    end else begin
      if (w_load) begin
        r_cur_op  <= w_head_op;
        r_cur_row <= w_head_row;
        r_cmd     <= (w_head_op == OP_ILLEGAL) ? 32'h0
                     : {flash_opcode(w_head_op), 24'(w_head_row)};
      end else if (r_state == ST_REPORT) begin
        r_cmd <= '0;
      end
      r_code <= w_code_nxt;
      if (r_state == ST_ISSUE)
        r_timer <= '0;
      else if (r_state == ST_WAIT && r_timer != TIMER_MAX)
        r_timer <= r_timer + 1'b1;
    end
  end

  assign req_ready = !w_full;
  assign cmd       = r_cmd;
  assign start_trs = (r_state == ST_ISSUE) && (r_cur_op != OP_ILLEGAL);
  assign sts_valid = (r_state == ST_REPORT);
  assign sts_code  = sts_valid ? r_code    : STS_OK;
  assign sts_op    = sts_valid ? r_cur_op  : OP_ILLEGAL;
  assign sts_row   = sts_valid ? r_cur_row : '0;
  assign idle      = (r_state == ST_IDLE) && w_empty;

endmodule

// File: tb/tb_nand_cmd_scheduler.sv
// Self-checking bench for nand_cmd_scheduler: directed scenarios plus a random
// phase, compared against a queue-based request model.
`timescale 1ns/1ps
module tb_nand_cmd_scheduler;

  localparam int QDEPTH      = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int ROW_W       = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic [1:0]       req_op;
  logic [ROW_W-1:0] req_row;
  logic             req_ready;
  logic [31:0]      cmd;
  logic             start_trs;
  logic             done_w, done_r, done_e, busy_noresp;
  logic             sts_valid;
  logic [1:0]       sts_code;
  logic [1:0]       sts_op;
  logic [ROW_W-1:0] sts_row;
  logic [2:0]       q_count;
  logic             idle;

  nand_cmd_scheduler #(
    .QDEPTH      (QDEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ROW_W       (ROW_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_row     (req_row),
    .req_ready   (req_ready),
    .cmd         (cmd),
    .start_trs   (start_trs),
    .done_w      (done_w),
    .done_r      (done_r),
    .done_e      (done_e),
    .busy_noresp (busy_noresp),
    .sts_valid   (sts_valid),
    .sts_code    (sts_code),
    .sts_op      (sts_op),
    .sts_row     (sts_row),
    .q_count     (q_count),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [ROW_W-1:0] row;
  } req_t;

  req_t model_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   push_cyc = 0;
  bit   pend_pop = 1'b0;

  // Mode of completion: 0 done, 1 wrong dones then done, 2 timeout, 3 noresp+done
  function automatic int exp_code(input int mode);
    case (mode)
      2:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_cmd(input req_t r);
    logic [7:0] opc;
    case (r.op)
      2'd1:    opc = 8'h01;
      2'd2:    opc = 8'h02;
      2'd3:    opc = 8'h03;
      default: opc = 8'h00;
    endcase
    if (r.op == 2'd0) return 32'h0;
    return {opc, r.row};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pend_pop) begin
      model_q.delete(0);
      pend_pop = 1'b0;
    end
  endtask

  task automatic pulse(input int which, input bit noresp);
    done_w      = (which == 1);
    done_r      = (which == 2);
    done_e      = (which == 3);
    busy_noresp = noresp;
    tick();
    done_w = 1'b0; done_r = 1'b0; done_e = 1'b0; busy_noresp = 1'b0;
  endtask

  // Hold a request until the FIFO takes it; a full FIFO refuses even on a pop.
  task automatic push(input logic [1:0] op, input logic [ROW_W-1:0] row);
    req_t r;
    bit   accepted;
    bit   exp_rdy;
    int   n;
    r.op = op; r.row = row;
    accepted = 1'b0;
    n = 0;
    req_valid = 1'b1; req_op = op; req_row = row;
    while (!accepted && n < 300) begin
      exp_rdy = (model_q.size() < QDEPTH);
      check("req_ready", req_ready, exp_rdy);
      push_cyc = cyc;
      tick();
      if (exp_rdy) begin
        model_q.push_back(r);
        accepted = 1'b1;
      end
      n++;
    end
    req_valid = 1'b0;
    if (!accepted) check("push_accept_timeout", 32'd0, 32'd1);
    check("q_count", q_count, model_q.size());
  endtask

  task automatic serve_start();
    int n;
    n = 0;
    while (start_trs !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("start_trs_seen", start_trs, 1);
    start_cyc = cyc;
    check("cmd_at_issue", cmd, exp_cmd(model_q[0]));
    tick();
    check("start_trs_one_cycle", start_trs, 0);
    check("cmd_stable_wait", cmd, exp_cmd(model_q[0]));
  endtask

  task automatic serve_end(input int mode);
    req_t h;
    h = model_q[0];
    case (mode)
      0: begin
        repeat ($urandom_range(0, 6)) tick();
        pulse(h.op, 1'b0);
      end
      1: begin
        for (int o = 1; o <= 3; o++) begin
          if (o != int'(h.op)) begin
            pulse(o, 1'b0);
            check("wrong_done_ignored", sts_valid, 0);
          end
        end
        pulse(h.op, 1'b0);
      end
      2: begin
        while (sts_valid !== 1'b1 && (cyc - start_cyc) < 200) tick();
        check("timeout_latency", cyc - start_cyc, TIMEOUT_CYC + 1);
      end
      default: pulse(h.op, 1'b1);
    endcase
    check("sts_valid", sts_valid, 1);
    check("sts_code", sts_code, exp_code(mode));
    check("sts_op", sts_op, h.op);
    check("sts_row", sts_row, h.row);
    pend_pop = 1'b1;
  endtask

  task automatic serve_bad();
    req_t h;
    int   n;
    h = model_q[0];
    n = 0;
    while (sts_valid !== 1'b1 && n < 10) begin
      check("badop_no_start", start_trs, 0);
      tick();
      n++;
    end
    check("badop_sts_valid", sts_valid, 1);
    check("badop_code", sts_code, 3);
    check("badop_op", sts_op, 0);
    check("badop_row", sts_row, h.row);
    pend_pop = 1'b1;
  endtask

  task automatic finish_report();
    tick();
    check("sts_valid_one_cycle", sts_valid, 0);
    check("cmd_cleared", cmd, 0);
    check("idle", idle, model_q.size() == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]       op;
    logic [ROW_W-1:0] row;
    logic [1:0]       op5;
    logic [ROW_W-1:0] row5;

    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_row = '0;
    done_w = 1'b0; done_r = 1'b0; done_e = 1'b0; busy_noresp = 1'b0;
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_q_count", q_count, 0);
    check("rst_cmd", cmd, 0);
    check("rst_start_trs", start_trs, 0);
    check("rst_sts_valid", sts_valid, 0);
    rst = 1'b0;
    tick();

    // Single write, issue latency and status
    push(2'd1, 24'h000123);
    serve_start();
    check("issue_latency", start_cyc - push_cyc, 2);
    repeat (8) tick();
    serve_end(0);
    finish_report();

    // Fill the FIFO while one request is in flight; fifth push is refused
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    serve_start();
    for (int i = 0; i < 3; i++) push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    op5 = 2'($urandom_range(1, 3));
    row5 = ROW_W'($urandom);
    check("req_ready_full", req_ready, 0);
    req_valid = 1'b1; req_op = op5; req_row = row5;
    tick();
    req_valid = 1'b0;
    check("q_count_full_refused", q_count, 4);
    serve_end(0);
    push(op5, row5);
    for (int i = 0; i < 4; i++) begin
      serve_start();
      serve_end(0);
    end
    finish_report();

    // Erase with wrong done pulses first
    push(2'd3, 24'h00ABCD);
    serve_start();
    serve_end(1);
    finish_report();

    // Read timeout, then the queued request still issues
    push(2'd2, 24'h000010);
    serve_start();
    push(2'd1, ROW_W'($urandom));
    serve_end(2);
    serve_start();
    serve_end(0);
    finish_report();

    // Noresp beats a matching done; illegal op reports BADOP
    push(2'd1, ROW_W'($urandom));
    serve_start();
    serve_end(3);
    finish_report();
    push(2'd0, ROW_W'($urandom));
    serve_bad();
    finish_report();

    // Push during REPORT's pop leaves occupancy unchanged
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    serve_start();
    serve_end(0);
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    for (int i = 0; i < 2; i++) begin
      serve_start();
      serve_end(0);
    end
    finish_report();

    // Random requests and completion modes
    for (int i = 0; i < 8; i++) begin
      op  = 2'($urandom_range(0, 3));
      row = ROW_W'($urandom);
      push(op, row);
      if (op == 2'd0) serve_bad();
      else begin
        serve_start();
        serve_end($urandom_range(0, 3));
      end
      finish_report();
    end

    // Reset during WAIT with three entries queued
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    serve_start();
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    push(2'($urandom_range(1, 3)), ROW_W'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_q.delete();
    pend_pop = 1'b0;
    check("midrst_q_count", q_count, 0);
    check("midrst_sts_valid", sts_valid, 0);
    check("midrst_start_trs", start_trs, 0);
    check("midrst_cmd", cmd, 0);
    check("midrst_idle", idle, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("postrst_no_start", start_trs, 0);
      check("postrst_no_sts", sts_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
